exe_stage: RTL

- Execute stage (pipe #5). Sits directly downstream of the issue stage and consumes its pipe #4 outputs.
- Computes ALU, LUI/AUIPC, jump-link and M-extension results. Resolves branches and jumps, and forms memory addresses.
- Registers all results into pipe #5 for the memory/commit stages.
- DIV/DIVU/REM/REMU run on an iterative radix-2 divider that stalls upstream. MUL* complete in a single cycle.

---
 rtl/core_pkg.sv | 55 +++++
 rtl/divider_iter.sv | 127 ++++++++++++
 rtl/exe_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the execute stage and its divider.
//   XLEN        : datapath width
//   alu_fn_e    : ALU control codes, {funct7[5], funct3}
//   br_fn_e     : conditional-branch funct3 codes
//   m_op_e      : M-extension funct3 codes
//   div_state_e : iterative divider FSM states
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_fn_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_fn_e;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All divide-class M ops have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] m_op);
    return m_op[2];
  endfunction

endpackage

// File: rtl/divider_iter.sv
// divider_iter: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk, nrst     : clock, asynchronous active-low reset (aborts any division)
//   i_start       : divide op present at the execute stage
//   i_signed_op   : DIV/REM (signed) vs DIVU/REMU
//   i_rem_sel     : select remainder instead of quotient
//   i_a, i_b      : dividend, divisor
//   o_busy        : upstream must hold (accepting a long divide, or iterating)
//   o_done        : final result is on o_result this cycle
//   o_active      : FSM is outside IDLE
//   o_result      : divide result; in IDLE it carries the single-cycle special
//                   cases (divide by zero, signed overflow)
module divider_iter #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_start,
  input  logic            i_signed_op,
  input  logic            i_rem_sel,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_active,
  output logic [XLEN-1:0] o_result
);
  import core_pkg::*;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  div_state_e      r_state;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_rem_sel;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_q;
  logic [XLEN-1:0] w_spec_r;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;

  assign w_a_neg = i_signed_op & i_a[XLEN-1];
  assign w_b_neg = i_signed_op & i_b[XLEN-1];
  assign w_a_abs = w_a_neg ? -i_a : i_a;
  assign w_b_abs = w_b_neg ? -i_b : i_b;

  // Cases resolved without iterating: x/0 and MIN/-1.
  assign w_div0    = (i_b == '0);
  assign w_ovf     = i_signed_op & (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_b);
  assign w_special = w_div0 | w_ovf;
  // Overflow quotient equals the dividend (MIN), remainder 0.
  assign w_spec_q  = w_div0 ? '1  : i_a;
  assign w_spec_r  = w_div0 ? i_a : '0;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. r_quo doubles as the
  // dividend shift register and the quotient accumulator.
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[XLEN];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start && !w_special) begin
            r_state   <= BUSY;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_abs;
            r_dvs     <= w_b_abs;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem_sel <= i_rem_sel;
          end
        end
        BUSY: begin
          r_rem   <= w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_quo   <= {r_quo[XLEN-2:0], w_ge};
          r_count <= r_count + 1'b1;
          if (r_count == CW'(DIV_CYCLES - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_q_fin = r_neg_q ? -r_quo : r_quo;
  assign w_r_fin = r_neg_r ? -r_rem : r_rem;

  assign o_busy   = (r_state == BUSY) | ((r_state == IDLE) & i_start & ~w_special);
  assign o_done   = (r_state == DONE);
  assign o_active = (r_state != IDLE);
  assign o_result = (r_state == DONE) ? (r_rem_sel ? w_r_fin : w_q_fin)
                                      : (i_rem_sel ? w_spec_r : w_spec_q);

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage (pipe #5). Computes ALU, LUI/AUIPC, link and
// M-extension results, resolves branches/jumps, forms memory addresses and
// registers everything into pipe #5.
//   clk, nrst            : clock, asynchronous active-low reset
//   we4, rd4             : write-enable / destination from issue
//   btype4, fn4          : conditional branch and its condition
//   pcselect4            : pc-select passthrough
//   op_a, op_b           : operands (op_b already muxed with imm/shamt)
//   store_data4          : store data (rs2)
//   alu_fn4              : ALU control {funct7[5], funct3}
//   pc4, *_imm4          : pc and decoded immediates
//   j4, jr4, LUI4, auipc4: instruction-class flags
//   mem_op4              : memory op (0 none, bit3 store)
//   m_en4, m_op4         : M-extension op
//   we5, rd5, result5, store_data5, mem_op5, pcselect5 : pipe #5 registers
//   btaken, target_pc    : combinational redirect
//   stall_ex             : combinational hold for pipe #4 and earlier
module exe_stage #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            we4,
  input  logic            btype4,
  input  logic [2:0]      fn4,
  input  logic [1:0]      pcselect4,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] store_data4,
  input  logic [4:0]      rd4,
  input  logic [3:0]      alu_fn4,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] B_imm4,
  input  logic [XLEN-1:0] J_imm4,
  input  logic [XLEN-1:0] S_imm4,
  input  logic [XLEN-1:0] U_imm4,
  input  logic            j4,
  input  logic            jr4,
  input  logic            LUI4,
  input  logic            auipc4,
  input  logic [3:0]      mem_op4,
  input  logic            m_en4,
  input  logic [2:0]      m_op4,
  output logic            we5,
  output logic [4:0]      rd5,
  output logic [XLEN-1:0] result5,
  output logic [XLEN-1:0] store_data5,
  output logic [3:0]      mem_op5,
  output logic [1:0]      pcselect5,
  output logic            btaken,
  output logic [XLEN-1:0] target_pc,
  output logic            stall_ex
);
  import core_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic              w_cond;
  logic              w_bt_raw;
  logic [XLEN-1:0]   w_tgt_raw;
  logic [XLEN-1:0]   w_jr_sum;
  logic              w_a_sext;
  logic              w_b_sext;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_m_res;
  logic [XLEN-1:0]   w_addr;
  logic [XLEN-1:0]   w_result;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic              w_div_active;
  logic [XLEN-1:0]   w_div_res;
  logic              w_redirect_en;

  // ---------------- ALU ----------------
  assign w_shamt = op_b[SHW-1:0];

  always_comb begin
    w_alu = op_a + op_b;
    case (alu_fn_e'(alu_fn4))
      ALU_ADD:  w_alu = op_a + op_b;
      ALU_SUB:  w_alu = op_a - op_b;
      ALU_SLL:  w_alu = op_a << w_shamt;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  w_alu = op_a ^ op_b;
      ALU_SRL:  w_alu = op_a >> w_shamt;
      ALU_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
      ALU_OR:   w_alu = op_a | op_b;
      ALU_AND:  w_alu = op_a & op_b;
      default:  w_alu = op_a + op_b;
    endcase
  end

  // ---------------- Branch / jump resolution ----------------
  always_comb begin
    w_cond = 1'b0;
    case (br_fn_e'(fn4))
      BR_EQ:   w_cond = (op_a == op_b);
      BR_NE:   w_cond = (op_a != op_b);
      BR_LT:   w_cond = ($signed(op_a) < $signed(op_b));
      BR_GE:   w_cond = ($signed(op_a) >= $signed(op_b));
      BR_LTU:  w_cond = (op_a < op_b);
      BR_GEU:  w_cond = (op_a >= op_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jr_sum = op_a + op_b;
  assign w_bt_raw = j4 | jr4 | (btype4 & w_cond);

  always_comb begin
    w_tgt_raw = '0;
    if (jr4) begin
      w_tgt_raw = {w_jr_sum[XLEN-1:1], 1'b0};
    end else if (j4) begin
      w_tgt_raw = pc4 + J_imm4;
    end else if (btype4) begin
      w_tgt_raw = pc4 + B_imm4;
    end
  end

  // No redirect while in reset or while a long divide occupies the stage.
  assign w_redirect_en = nrst & ~w_div_active;
  assign btaken        = w_redirect_en & w_bt_raw;
  assign target_pc     = w_redirect_en ? w_tgt_raw : '0;

  // ---------------- Multiplier ----------------
  // One 2*XLEN product of sign/zero-extended operands covers all four MUL
  // variants; only the extension of each operand differs.
  assign w_a_sext  = ((m_op4 == M_MULH) | (m_op4 == M_MULHSU)) & op_a[XLEN-1];
  assign w_b_sext  = (m_op4 == M_MULH) & op_b[XLEN-1];
  assign w_ma      = {{XLEN{w_a_sext}}, op_a};
  assign w_mb      = {{XLEN{w_b_sext}}, op_b};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (m_op4 == M_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------- Divider ----------------
  assign w_div_start = m_en4 & is_div_op(m_op4);

  divider_iter #(
    .XLEN       (XLEN),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .nrst        (nrst),
    .i_start     (w_div_start),
    .i_signed_op (~m_op4[0]),
    .i_rem_sel   (m_op4[1]),
    .i_a         (op_a),
    .i_b         (op_b),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_active    (w_div_active),
    .o_result    (w_div_res)
  );

  assign stall_ex = nrst & w_div_busy & ~w_div_done;
  assign w_m_res  = is_div_op(m_op4) ? w_div_res : w_mul_res;

  // ---------------- Result select ----------------
  assign w_addr = mem_op4[3] ? (op_a + S_imm4) : (op_a + op_b);

  always_comb begin
    w_result = w_alu;
    if (LUI4) begin
      w_result = U_imm4;
    end else if (auipc4) begin
      w_result = pc4 + U_imm4;
    end else if (j4 | jr4) begin
      w_result = pc4 + XLEN'(4);
    end else if (m_en4) begin
      w_result = w_m_res;
    end else if (mem_op4 != 4'd0) begin
      w_result = w_addr;
    end
  end

  // ---------------- Pipe #5 ----------------
  // A stall turns the stage output into a bubble; data fields still load but
  // are never consumed without we5/mem_op5.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      we5         <= 1'b0;
      rd5         <= '0;
      result5     <= '0;
      store_data5 <= '0;
      mem_op5     <= '0;
      pcselect5   <= '0;
    end else begin
      result5     <= w_result;
      store_data5 <= store_data4;
      if (stall_ex) begin
        we5       <= 1'b0;
        rd5       <= '0;
        mem_op5   <= '0;
        pcselect5 <= '0;
      end else begin
        we5       <= we4;
        rd5       <= rd4;
        mem_op5   <= mem_op4;
        pcselect5 <= pcselect4;
      end
    end
  end

endmodule
